spram_bist: RTL and testbench
=============================

SPRAM_BIST -- requirements
Module: spram_bist

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the memory word width in bits.
REQ-002 The block SHALL have parameter DATA_DEPTH, default 256, meaning the number of words tested; AW = $clog2(DATA_DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a test run; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate a running test.
REQ-007 The block SHALL have port pattern, input, 2 bits: 0 = stripe (even 0x5A.., odd 0xA5..), 1 = address value (zero-extended or truncated to DATA_WIDTH), 2 = all ones, 3 = all zeros.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a test runs.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a completed run.
REQ-010 The block SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-011 The block SHALL have port err_count, output, AW+1 bits: number of mismatching words.
REQ-012 The block SHALL have port fail_addr, output, AW bits: lowest failing address.
REQ-013 The block SHALL have memory master ports mem_en (output, 1), mem_wr_en (output, 1), mem_addr (output, AW), mem_wr_data (output, DATA_WIDTH), and mem_rd_data (input, DATA_WIDTH).
REQ-014 The memory SHALL be treated as synchronous: mem_rd_data is valid in the cycle after an edge with mem_en=1 and mem_wr_en=0, and it holds its value while mem_en=0.

Function
REQ-015 The state machine SHALL use states IDLE, WRITE, READ, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL latch pattern, clear err_count, fail_addr and pass, set busy, and move to WRITE with address 0.
REQ-017 In WRITE, each cycle SHALL drive mem_en=1, mem_wr_en=1 and mem_wr_data=pattern(addr); addr increments from 0 to DATA_DEPTH-1, then the FSM moves to READ with addr reset to 0.
REQ-018 In READ, each cycle SHALL drive mem_en=1 and mem_wr_en=0; after DATA_DEPTH-1, the FSM moves to DRAIN.
REQ-019 Compare SHALL be pipelined: the read issued for address a is compared against pattern(a) in the following cycle (READ or DRAIN), with a one-stage registered expected address.
REQ-020 On a mismatch, err_count SHALL increment, saturating at DATA_DEPTH, and fail_addr SHALL be captured only on the first mismatch.
REQ-021 DRAIN SHALL perform the final compare with mem_en=0, then move to DONE.
REQ-022 In DONE, done=1 for exactly one cycle, pass = (err_count==0) including the final compare, busy=0, and the FSM returns to IDLE.
REQ-023 The run latency SHALL be exactly 2*DATA_DEPTH+2 cycles from the start-sampling edge to the edge that asserts done.
REQ-024 Outside WRITE and READ, mem_en and mem_wr_en SHALL be 0.
REQ-025 start while busy SHALL be ignored; pattern changes mid-run SHALL have no effect.
REQ-026 abort while busy SHALL force IDLE on the next edge: mem_en=0, busy=0, no done pulse, and pass=0.
REQ-027 Simultaneous abort and the final DONE cycle SHALL let abort win: no done pulse.
REQ-028 pass, err_count and fail_addr SHALL hold their values until the next accepted start.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE and set busy, done, pass, err_count, fail_addr, mem_en, mem_wr_en, mem_addr and mem_wr_data to 0, including mid-run.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Package spram_bist_pkg SHALL hold the FSM state enum and the pattern code constants (PAT_STRIPE, PAT_ADDR, PAT_ONES, PAT_ZEROS).
REQ-032 Sub-module spram_bist_pattern SHALL implement the combinational pattern(addr, code) generator; two instances (write address and compare address) are permitted.

Verification (bench uses spram, DATA_WIDTH=8, DATA_DEPTH=256)
REQ-033 Verification SHALL cover: start, pattern=0 -> done at cycle 514, pass=1, err_count=0; memory word 0 = 0x5A, word 1 = 0xA5.
REQ-034 Verification SHALL cover: pattern=1 -> memory word i = i, and pass=1.
REQ-035 Verification SHALL cover fault injection: rd_data XOR 0x01 at addresses 7 and 200 -> pass=0, err_count=2, fail_addr=7.
REQ-036 Verification SHALL cover: fault on address 255 only -> the DRAIN compare catches it, giving err_count=1 and fail_addr=255.
REQ-037 Verification SHALL cover: abort at cycle 300 -> busy=0 the next cycle, no done pulse, pass=0, and a following start runs cleanly.
REQ-038 Verification SHALL cover: rst asserted mid-WRITE -> all outputs 0 asynchronously, and start is ignored while busy (a second start at cycle 10 does not change latency).

Source files
------------

// File: rtl/spram_bist_pkg.sv
// Shared types and constants for the single-port RAM built-in self test.
package spram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] PAT_STRIPE = 2'd0;
  localparam logic [1:0] PAT_ADDR   = 2'd1;
  localparam logic [1:0] PAT_ONES   = 2'd2;
  localparam logic [1:0] PAT_ZEROS  = 2'd3;

endpackage

// File: rtl/spram_bist_pattern.sv
// Combinational test-word generator: maps (address, pattern code) to the
// word written during WRITE and expected during compare.
module spram_bist_pattern
  import spram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 8
) (
  input  logic [AW-1:0]         i_addr,
  input  logic [1:0]            i_code,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int REP = (DATA_WIDTH + 7) / 8;

  logic [REP*8-1:0]           w_stripe_even;
  logic [REP*8-1:0]           w_stripe_odd;
  logic [DATA_WIDTH+AW-1:0]   w_addr_ext;

  // Wide words repeat the byte stripe; address is zero-extended or truncated.
  assign w_stripe_even = {REP{8'h5A}};
  assign w_stripe_odd  = {REP{8'hA5}};
  assign w_addr_ext    = {{DATA_WIDTH{1'b0}}, i_addr};

  always_comb begin
    o_data = '0;
    case (i_code)
      PAT_STRIPE: o_data = i_addr[0] ? w_stripe_odd[DATA_WIDTH-1:0]
                                     : w_stripe_even[DATA_WIDTH-1:0];
      PAT_ADDR:   o_data = w_addr_ext[DATA_WIDTH-1:0];
      PAT_ONES:   o_data = '1;
      default:    o_data = '0;
    endcase
  end

endmodule

// File: rtl/spram_bist.sv
// March-style write-then-read BIST for a synchronous single-port RAM with a
// one-stage pipelined compare, error counting and first-failure capture.
module spram_bist
  import spram_bist_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DATA_DEPTH = 256,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW:0]           err_count,
  output logic [AW-1:0]         fail_addr,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DATA_DEPTH - 1);
  localparam logic [AW:0]   ERR_MAX   = (AW + 1)'(DATA_DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [AW:0]           r_err_count;
  logic [AW-1:0]         r_fail_addr;
  logic [AW-1:0]         r_addr;
  logic [1:0]            r_pat_code;
  logic                  r_cmp_vld_p1;
  logic [AW-1:0]         r_cmp_addr_p1;

  logic                  w_mem_en;
  logic                  w_mem_wr_en;
  logic                  w_addr_last;
  logic                  w_abort;
  logic                  w_mismatch;
  logic [DATA_WIDTH-1:0] w_wr_pat;
  logic [DATA_WIDTH-1:0] w_exp_pat;

  assign w_addr_last = (r_addr == ADDR_LAST);
  assign w_abort     = abort && r_busy;

  spram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_wr_pat (
    .i_addr (r_addr),
    .i_code (r_pat_code),
    .o_data (w_wr_pat)
  );

  spram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_exp_pat (
    .i_addr (r_cmp_addr_p1),
    .i_code (r_pat_code),
    .o_data (w_exp_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_wr_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_mem_en    = 1'b1;
        w_mem_wr_en = 1'b1;
        if (w_abort)          w_state_nxt = IDLE;
        else if (w_addr_last) w_state_nxt = READ;
      end
      READ: begin
        w_mem_en = 1'b1;
        if (w_abort)          w_state_nxt = IDLE;
        else if (w_addr_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_state_nxt = w_abort ? IDLE : DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // p1: read data for r_cmp_addr_p1 is on mem_rd_data this cycle
  assign w_mismatch = r_cmp_vld_p1 && (mem_rd_data != w_exp_pat);

  always_ff @(posedge clk) begin
    if (r_state == READ) r_cmp_addr_p1 <= r_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_addr  <= '0;
      r_addr       <= '0;
      r_pat_code   <= PAT_STRIPE;
      r_cmp_vld_p1 <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_cmp_vld_p1 <= 1'b0;

      if (w_mismatch && !w_abort) begin
        if (r_err_count != ERR_MAX) r_err_count <= r_err_count + (AW + 1)'(1);
        if (r_err_count == '0)      r_fail_addr <= r_cmp_addr_p1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_pat_code  <= pattern;
            r_err_count <= '0;
            r_fail_addr <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_addr      <= '0;
          end
        end
        WRITE: begin
          r_addr <= w_addr_last ? '0 : r_addr + AW'(1);
        end
        READ: begin
          r_addr       <= w_addr_last ? '0 : r_addr + AW'(1);
          r_cmp_vld_p1 <= 1'b1;
        end
        DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err_count == '0);
          r_busy <= 1'b0;
        end
        default: ;
      endcase

      // Abort overrides everything, including a coincident DONE cycle.
      if (w_abort) begin
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_addr       <= '0;
        r_cmp_vld_p1 <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_count   = r_err_count;
  assign fail_addr   = r_fail_addr;
  assign mem_en      = w_mem_en;
  assign mem_wr_en   = w_mem_wr_en;
  assign mem_addr    = r_addr;
  assign mem_wr_data = w_mem_wr_en ? w_wr_pat : '0;

endmodule

// File: tb/tb_spram_bist.sv
// Directed bench for spram_bist driving a behavioural synchronous RAM with
// optional single-bit read-data fault injection per address.
module tb_spram_bist;

  localparam int DW = 8;
  localparam int DD = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    pattern;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  logic [DW-1:0] mem [DD];
  logic [DW-1:0] r_rdq;
  logic [AW-1:0] r_rd_addr;
  bit            fault_en [DD];

  int n_chk  = 0;
  int n_fail = 0;

  spram_bist #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_addr   (fail_addr),
    .mem_en      (mem_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      else begin
        r_rdq     <= mem[mem_addr];
        r_rd_addr <= mem_addr;
      end
    end
  end

  assign mem_rd_data = r_rdq ^ (fault_en[r_rd_addr] ? 8'h01 : 8'h00);

  // Starts a run; optionally re-asserts start with a different pattern at
  // cycle start2_at. lat = cycles from start-sampling edge to done, -1 on timeout.
  task automatic do_run(input logic [1:0] pat, input int start2_at, output int lat);
    pattern = pat;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 1000; n++) begin
      if (n == start2_at) begin
        start   = 1'b1;
        pattern = ~pat;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start   = 1'b0;
    pattern = pat;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, pass, err_count, fail_addr, mem_en, mem_wr_en, mem_addr, mem_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d fa=%0d en=%b we=%b addr=%0d wd=%h, required all 0",
               busy, done, pass, err_count, fail_addr, mem_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: busy=%b required 0", busy); end
    n_chk++;
    if (mem_en !== 1'b0) begin n_fail++; $display("FAIL idle_mem_en: mem_en=%b required 0", mem_en); end
  endtask

  task automatic test_stripe;
    int lat;
    do_run(2'd0, 0, lat);
    n_chk++;
    if (lat !== 514) begin n_fail++; $display("FAIL stripe_latency: got %0d required 514", lat); end
    n_chk++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL stripe_pass: got %b required 1", pass); end
    n_chk++;
    if (err_count !== 9'd0) begin n_fail++; $display("FAIL stripe_err: got %0d required 0", err_count); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stripe_busy: got %b required 0", busy); end
    n_chk++;
    if (mem[0] !== 8'h5A) begin n_fail++; $display("FAIL stripe_word0: got %h required 5a", mem[0]); end
    n_chk++;
    if (mem[1] !== 8'hA5) begin n_fail++; $display("FAIL stripe_word1: got %h required a5", mem[1]); end
    n_chk++;
    if (mem[255] !== 8'hA5) begin n_fail++; $display("FAIL stripe_word255: got %h required a5", mem[255]); end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: done=%b required 0", done); end
  endtask

  task automatic test_addr;
    int lat;
    int bad;
    do_run(2'd1, 0, lat);
    n_chk++;
    if (lat !== 514) begin n_fail++; $display("FAIL addr_latency: got %0d required 514", lat); end
    n_chk++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL addr_pass: got %b required 1", pass); end
    bad = 0;
    for (int i = 0; i < DD; i++) if (mem[i] !== 8'(i)) bad++;
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL addr_words: %0d words differ from their address, required 0", bad); end
  endtask

  task automatic test_fault;
    int lat;
    fault_en[7]   = 1'b1;
    fault_en[200] = 1'b1;
    do_run(2'd2, 0, lat);
    fault_en[7]   = 1'b0;
    fault_en[200] = 1'b0;
    n_chk++;
    if (lat !== 514) begin n_fail++; $display("FAIL fault_latency: got %0d required 514", lat); end
    n_chk++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL fault_pass: got %b required 0", pass); end
    n_chk++;
    if (err_count !== 9'd2) begin n_fail++; $display("FAIL fault_err: got %0d required 2", err_count); end
    n_chk++;
    if (fail_addr !== 8'd7) begin n_fail++; $display("FAIL fault_addr: got %0d required 7", fail_addr); end
    n_chk++;
    if (mem[200] !== 8'hFF) begin n_fail++; $display("FAIL ones_word200: got %h required ff", mem[200]); end
  endtask

  task automatic test_drain_fault;
    int lat;
    fault_en[255] = 1'b1;
    do_run(2'd3, 0, lat);
    fault_en[255] = 1'b0;
    n_chk++;
    if (err_count !== 9'd1) begin n_fail++; $display("FAIL drain_err: got %0d required 1", err_count); end
    n_chk++;
    if (fail_addr !== 8'd255) begin n_fail++; $display("FAIL drain_addr: got %0d required 255", fail_addr); end
    n_chk++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL drain_pass: got %b required 0", pass); end
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (err_count !== 9'd1) begin n_fail++; $display("FAIL hold_err: got %0d required 1", err_count); end
    n_chk++;
    if (fail_addr !== 8'd255) begin n_fail++; $display("FAIL hold_addr: got %0d required 255", fail_addr); end
    n_chk++;
    if (mem[10] !== 8'h00) begin n_fail++; $display("FAIL zeros_word10: got %h required 00", mem[10]); end
  endtask

  task automatic test_reset_mid;
    int lat;
    pattern = 2'd1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++;
    if ({mem_en, mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 1'b1, 8'd20, 8'd20}) begin
      n_fail++;
      $display("FAIL mid_write: en=%b we=%b addr=%0d wd=%h required 1 1 20 14", mem_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, pass, err_count, fail_addr, mem_en, mem_wr_en, mem_addr, mem_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b pass=%b err=%0d fa=%0d en=%b we=%b addr=%0d wd=%h, required all 0",
               busy, done, pass, err_count, fail_addr, mem_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_run(2'd0, 10, lat);
    n_chk++;
    if (lat !== 514) begin n_fail++; $display("FAIL busy_start_latency: got %0d required 514", lat); end
    n_chk++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL busy_start_pass: got %b required 1", pass); end
    n_chk++;
    if (mem[100] !== 8'h5A) begin n_fail++; $display("FAIL pattern_latched: got %h required 5a", mem[100]); end
  endtask

  task automatic test_abort;
    int lat;
    int dcount;
    pattern = 2'd0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b required 1", busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
    n_chk++;
    if (mem_en !== 1'b0) begin n_fail++; $display("FAIL abort_mem_en: got %b required 0", mem_en); end
    n_chk++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL abort_pass: got %b required 0", pass); end
    dcount = 0;
    for (int i = 0; i < 600; i++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (dcount !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d done cycles, required 0", dcount); end
    do_run(2'd0, 0, lat);
    n_chk++;
    if (lat !== 514) begin n_fail++; $display("FAIL post_abort_latency: got %0d required 514", lat); end
    n_chk++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL post_abort_pass: got %b required 1", pass); end
  endtask

  task automatic test_abort_at_done;
    int dcount;
    @(posedge clk); #1;
    pattern = 2'd2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (513) @(posedge clk);
    #1;
    abort = 1'b1;
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      if (done === 1'b1) dcount++;
    end
    n_chk++;
    if (dcount !== 0) begin n_fail++; $display("FAIL abort_done_pulse: %0d done cycles, required 0", dcount); end
    n_chk++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL abort_done_pass: got %b required 0", pass); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_done_busy: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_stripe();
    test_addr();
    test_fault();
    test_drain_fault();
    test_reset_mid();
    test_abort();
    test_abort_at_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
